load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte-lane steering toward a word-wide memory and
// sign/zero extension of load data, with an ack timeout that abandons a stuck access.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0]  StIdle     = 2'd0;
  localparam logic [1:0]  StAccess   = 2'd1;
  localparam logic [1:0]  StResp     = 2'd2;
  localparam logic [15:0] TimeoutCnt = 16'(ACK_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;

  logic        req_mis, req_ill;
  logic [31:0] lane, load_data;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic        in_access;

  // Only legal half/word sizes can be misaligned; reserved codes are purely illegal.
  always_comb begin
    req_mis = 1'b0;
    req_ill = 1'b0;
    case (req_funct3)
      3'b000: req_ill = 1'b0;
      3'b001: req_mis = req_addr[0];
      3'b010: req_mis = |req_addr[1:0];
      3'b100: req_ill = req_write;
      3'b101: begin
        req_mis = req_addr[0];
        req_ill = req_write;
      end
      default: req_ill = 1'b1;
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be          = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be          = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be          = 4'b1111;
        wdata_lanes = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          write_d  = req_write;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          if (req_mis || req_ill) begin
            state_d = StResp;
            rdata_d = '0;
            mis_d   = req_mis;
            err_d   = ~req_mis;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (mem_ack) begin
          state_d = StResp;
          rdata_d = write_q ? 32'd0 : load_data;
          mis_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == TimeoutCnt) begin
            state_d = StResp;
            rdata_d = '0;
            mis_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
    end
  end

  assign in_access      = (state_q == StAccess);
  assign req_ready      = (state_q == StIdle);
  assign rsp_valid      = (state_q == StResp);
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = mis_q;
  assign rsp_error      = err_q;
  assign mem_req        = in_access;
  assign mem_we         = in_access & write_q;
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_be         = in_access ? be : 4'b0000;
  assign mem_wdata      = wdata_lanes;

endmodule
